// File: rtl/rst_sequencer.sv
// rst_sequencer: resynchronizes the external reset and releases per-stage resets in order at fixed spacing
module rst_sequencer #(
    parameter int NUM_STAGES      = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int STAGE_DELAY     = 16,
    parameter int SOFT_RST_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  async_rst_n,
    input  logic                  soft_rst_req,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  seq_busy,
    output logic                  seq_done
);
    localparam int MAX_CNT = STAGE_DELAY > SOFT_RST_CYCLES ? STAGE_DELAY : SOFT_RST_CYCLES;
    localparam int CW      = $clog2(MAX_CNT) + 1;
    localparam int KW      = $clog2(NUM_STAGES) + 1;

    typedef enum logic [1:0] {HOLD, RELEASE, DONE, SOFT} state_t;

    state_t                 state;
    logic [SYNC_STAGES-2:0] sync;
    logic [CW-1:0]          cnt;
    logic [KW-1:0]          k;

    // Synchronizer chain plus sequencing FSM; leaving HOLD is the final synchronizer
    // stage, so RELEASE starts on the same edge that int_rst_n would rise.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            sync        <= '0;
            state       <= HOLD;
            cnt         <= '0;
            k           <= '0;
            stage_rst_n <= '0;
            seq_busy    <= 1'b1;
            seq_done    <= 1'b0;
        end else begin
            sync <= (sync << 1) | (SYNC_STAGES-1)'(1);
            case (state)
                HOLD: begin
                    if (sync[SYNC_STAGES-2]) begin
                        state <= RELEASE;
                        cnt   <= '0;
                        k     <= '0;
                    end
                end
                RELEASE: begin
                    if (cnt == CW'(STAGE_DELAY - 1)) begin
                        stage_rst_n <= (stage_rst_n << 1) | NUM_STAGES'(1);
                        cnt         <= '0;
                        k           <= k + 1'b1;
                        if (k == KW'(NUM_STAGES - 1)) begin
                            state    <= DONE;
                            seq_busy <= 1'b0;
                            seq_done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (soft_rst_req) begin
                        state       <= SOFT;
                        stage_rst_n <= '0;
                        seq_busy    <= 1'b1;
                        seq_done    <= 1'b0;
                        cnt         <= '0;
                    end
                end
                SOFT: begin
                    if (cnt == CW'(SOFT_RST_CYCLES - 1)) begin
                        state <= RELEASE;
                        cnt   <= '0;
                        k     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= HOLD;
            endcase
        end
    end
endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: scoreboard bench; expected output changes are queued with their edge number
module tb_rst_sequencer;
    logic       clk = 1'b0;
    logic       async_rst_n = 1'b1;
    logic       soft_rst_req = 1'b0;
    logic       rst2_n = 1'b1;
    logic       req2 = 1'b1;
    logic [2:0] stage_rst_n;
    logic       seq_busy, seq_done;
    logic [0:0] stage2;
    logic       busy2, done2;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    typedef struct {int cyc; logic [4:0] val;} ev_t;
    ev_t q1[$];
    ev_t q2[$];
    ev_t e1, e2;

    rst_sequencer dut (
        .clk(clk), .async_rst_n(async_rst_n), .soft_rst_req(soft_rst_req),
        .stage_rst_n(stage_rst_n), .seq_busy(seq_busy), .seq_done(seq_done)
    );

    rst_sequencer #(.NUM_STAGES(1), .SYNC_STAGES(2), .STAGE_DELAY(1), .SOFT_RST_CYCLES(8)) dut2 (
        .clk(clk), .async_rst_n(rst2_n), .soft_rst_req(req2),
        .stage_rst_n(stage2), .seq_busy(busy2), .seq_done(done2)
    );

    // free-running clock and edge counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic push1(input int c, input logic [4:0] v);
        q1.push_back('{c, v});
    endtask

    task automatic push2(input int c, input logic [4:0] v);
        q2.push_back('{c, v});
    endtask

    task automatic check(input string name, input int got_c, input int exp_c, input logic [4:0] got, input logic [4:0] exp);
        total++;
        if (got_c != exp_c || got !== exp) begin
            bad++;
            $display("FAIL %s: got %b at edge %0d, expected %b at edge %0d", name, got, got_c, exp, exp_c);
        end
    endtask

    // monitor for the default instance: every output change must match the head of q1
    always @(stage_rst_n or seq_busy or seq_done) begin
        #1;
        if (q1.size() == 0) begin
            total++;
            bad++;
            $display("FAIL dut unexpected change to %b at edge %0d", {stage_rst_n, seq_busy, seq_done}, cyc);
        end else begin
            e1 = q1.pop_front();
            check("dut", cyc, e1.cyc, {stage_rst_n, seq_busy, seq_done}, e1.val);
        end
    end

    // monitor for the single-stage instance
    always @(stage2 or busy2 or done2) begin
        #1;
        if (q2.size() == 0) begin
            total++;
            bad++;
            $display("FAIL dut2 unexpected change to %b at edge %0d", {stage2, busy2, done2}, cyc);
        end else begin
            e2 = q2.pop_front();
            check("dut2", cyc, e2.cyc, {2'b00, stage2, busy2, done2}, e2.val);
        end
    end

    // single-stage instance with soft_rst_req held high from the start
    initial begin
        int b2;
        #2;
        push2(0, 5'b00010);
        rst2_n = 1'b0;
        repeat (5) @(negedge clk);
        b2 = cyc;
        for (int i = 0; i < 3; i++) begin
            push2(b2 + 3 + 10*i, 5'b00101);
            push2(b2 + 4 + 10*i, 5'b00010);
        end
        push2(b2 + 33, 5'b00101);
        rst2_n = 1'b1;
        while (cyc < b2 + 25) @(negedge clk);
        req2 = 1'b0;
    end

    // main stimulus for the default instance
    initial begin
        int base;
        int s0;
        #2;
        push1(0, 5'b00010);
        async_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        base = cyc;
        push1(base + 18, 5'b00110);
        push1(base + 34, 5'b01110);
        push1(base + 50, 5'b11101);
        async_rst_n = 1'b1;
        while (cyc < base + 24) @(negedge clk);
        soft_rst_req = 1'b1;
        @(negedge clk);
        soft_rst_req = 1'b0;
        while (cyc < base + 60) @(negedge clk);
        s0 = cyc + 1;
        push1(s0, 5'b00010);
        push1(s0 + 24, 5'b00110);
        push1(s0 + 40, 5'b01110);
        push1(s0 + 56, 5'b11101);
        soft_rst_req = 1'b1;
        @(negedge clk);
        soft_rst_req = 1'b0;
        while (cyc < s0 + 70) @(negedge clk);
        push1(cyc, 5'b00010);
        #2 async_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        base = cyc;
        push1(base + 18, 5'b00110);
        push1(base + 34, 5'b01110);
        async_rst_n = 1'b1;
        while (cyc < base + 40) @(negedge clk);
        push1(cyc, 5'b00010);
        #1 async_rst_n = 1'b0;
        #2 async_rst_n = 1'b1;
        base = cyc;
        push1(base + 18, 5'b00110);
        push1(base + 34, 5'b01110);
        push1(base + 50, 5'b11101);
        while (cyc < base + 60) @(negedge clk);
        s0 = cyc + 1;
        push1(s0, 5'b00010);
        soft_rst_req = 1'b1;
        @(negedge clk);
        soft_rst_req = 1'b0;
        while (cyc < s0 + 4) @(negedge clk);
        #1 async_rst_n = 1'b0;
        #2 async_rst_n = 1'b1;
        base = cyc;
        push1(base + 18, 5'b00110);
        push1(base + 34, 5'b01110);
        push1(base + 50, 5'b11101);
        while (cyc < base + 70) @(negedge clk);
        for (int i = 0; i < 100 && (q1.size() != 0 || q2.size() != 0); i++) @(negedge clk);
        while (q1.size() != 0) begin
            e1 = q1.pop_front();
            total++;
            bad++;
            $display("FAIL dut missing change to %b expected at edge %0d", e1.val, e1.cyc);
        end
        while (q2.size() != 0) begin
            e2 = q2.pop_front();
            total++;
            bad++;
            $display("FAIL dut2 missing change to %b expected at edge %0d", e2.val, e2.cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
